chan_data_mux: RTL
==================

CHAN_DATA_MUX -- requirements
Module: chan_data_mux

Interface
REQ-001 Parameters (name, default, meaning):
- PORTNUM, 16: number of input ports.
- DW, 32: data width in bits.
- LENW, 12: width of the beat counter.
- TIMEOUT, 255: maximum idle cycles in XFER before abort.
REQ-002 Ports (name, direction, width, meaning):
- i_clk, in, 1: clock.
- i_rst, in, 1: synchronous reset, active-high.
- i_chan_sel, in, $clog2(PORTNUM): granted port index from the channel arbiter.
- i_chan_en, in, 1: grant valid, level signal from the arbiter.
- i_data, in, PORTNUM*DW: port p data occupies bits [p*DW +: DW].
- i_vld, in, PORTNUM: per-port beat valid.
- i_eop, in, PORTNUM: per-port last beat of packet.
- o_port_rdy, out, PORTNUM: per-port ready; only the selected bit may be 1.
- o_data, out, DW: forwarded data.
- o_vld, out, 1: output beat valid.
- o_eop, out, 1: output last beat.
- i_ready, in, 1: downstream ready.
- o_end, out, 1: single-cycle pulse releasing the arbiter (drives its i_end).
- o_pkt_len, out, LENW: beats in the last packet.
- o_err, out, 1: last packet was aborted.

Function
REQ-003 The FSM SHALL have four states: IDLE, XFER, FLUSH, WAIT_CLR.
REQ-004 IDLE SHALL transition as follows: when i_chan_en=1, latch i_chan_sel into sel_q, clear the beat counter, and go to XFER the next cycle; otherwise stay.
REQ-005 In XFER, o_port_rdy[sel_q] SHALL equal (i_ready | ~o_vld); all other bits of o_port_rdy SHALL be 0 in every state.
REQ-006 A beat SHALL be accepted when i_vld[sel_q] & o_port_rdy[sel_q]; on the next edge o_data, o_eop and o_vld=1 SHALL be registered, giving a latency of exactly 1 cycle.
REQ-007 o_vld SHALL be cleared when i_ready=1 and no new beat is accepted; o_data, o_vld and o_eop SHALL hold while o_vld=1 and i_ready=0.
REQ-008 Inputs of non-selected ports SHALL be ignored.
REQ-009 Every accepted beat SHALL increment the beat counter; the counter SHALL saturate at 2^LENW-1 and not wrap.
REQ-010 An accepted beat with i_eop[sel_q]=1 SHALL move the FSM to FLUSH.
REQ-011 In FLUSH, the FSM SHALL stay until the final output beat is consumed (o_vld=0, or i_ready=1 on that cycle). It SHALL then:
- pulse o_end for exactly one cycle,
- load o_pkt_len from the counter and set o_err=0,
- go to WAIT_CLR.
REQ-012 WAIT_CLR SHALL return to IDLE on the first cycle i_chan_en=0; a grant still held high after o_end SHALL NOT restart a transfer.
REQ-013 A change of i_chan_sel while not in IDLE SHALL be ignored.
REQ-014 i_chan_en falling during XFER SHALL NOT abort the transfer; the packet SHALL complete normally.

Reset
REQ-015 While i_rst=1 at a clock edge, the block SHALL set:
- state=IDLE, sel_q=0, counter=0, idle counter=0;
- o_port_rdy=0, o_data=0, o_vld=0, o_eop=0, o_end=0, o_pkt_len=0, o_err=0.
REQ-016 Reset asserted mid-packet SHALL drop the packet immediately with no o_end pulse.

Configuration
REQ-017 Macro CHAN_DATA_MUX_TIMEOUT_EN SHALL control the XFER idle timeout.
- Defined: an idle counter SHALL count XFER cycles with no accepted beat and SHALL reset on every accepted beat. When it reaches TIMEOUT, the FSM SHALL force o_eop=1 on the next output slot if o_vld=0, otherwise mark the held beat as eop, then proceed as in FLUSH with o_err=1.
- Undefined: there SHALL be no idle counter, XFER SHALL wait indefinitely, and o_err SHALL be tied to 0.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Grant sel=3; port 3 sends 4 beats 0xA0..0xA3, eop on the last, i_ready=1 -> o_data matches 1 cycle later; o_end pulses once 1 cycle after the 0xA3 output cycle; o_pkt_len=4; o_err=0.
- Same packet with i_ready=0 for 3 cycles at beat 2 -> o_data holds 0xA1; o_port_rdy[3]=0 during the stall; no beat lost or duplicated.
- Ports 3 and 5 both valid, sel=5 -> only port-5 data appears; o_port_rdy=16'h0020 in XFER.
- i_chan_en held high 5 cycles after o_end -> FSM stays in WAIT_CLR; no second transfer until i_chan_en falls then rises.
- TIMEOUT_EN, TIMEOUT=8, port stops after 2 beats without eop -> 8 idle cycles later o_eop=1, o_end pulse, o_err=1, o_pkt_len=2.
- i_rst=1 during beat 2 of a packet -> all outputs 0 the next cycle, no o_end; a new grant then works normally.

Source files
------------

// File: rtl/chan_data_mux.sv
// Channel data mux: forwards the beat stream of the arbiter-granted port through one output register stage.
// Optional XFER idle-timeout abort is built when CHAN_DATA_MUX_TIMEOUT_EN is defined.
module chan_data_mux #(
    parameter int PORTNUM = 16,
    parameter int DW      = 32,
    parameter int LENW    = 12,
    parameter int TIMEOUT = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [$clog2(PORTNUM)-1:0] i_chan_sel,
    input  logic                       i_chan_en,
    input  logic [PORTNUM*DW-1:0]      i_data,
    input  logic [PORTNUM-1:0]         i_vld,
    input  logic [PORTNUM-1:0]         i_eop,
    output logic [PORTNUM-1:0]         o_port_rdy,
    output logic [DW-1:0]              o_data,
    output logic                       o_vld,
    output logic                       o_eop,
    input  logic                       i_ready,
    output logic                       o_end,
    output logic [LENW-1:0]            o_pkt_len,
    output logic                       o_err
);

    localparam int SELW = $clog2(PORTNUM);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        XFER     = 2'd1,
        FLUSH    = 2'd2,
        WAIT_CLR = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SELW-1:0] sel_q;
    logic [LENW-1:0] beat_cnt;

    logic [DW-1:0]   sel_data;
    logic            sel_vld;
    logic            sel_eop;
    logic            sel_rdy;
    logic            accept;
    logic            drained;
    logic            pkt_done;
    logic            timeout_hit;

    assign sel_data = i_data[sel_q*DW +: DW];
    assign sel_vld  = i_vld[sel_q];
    assign sel_eop  = i_eop[sel_q];
    assign sel_rdy  = i_ready | ~o_vld;
    assign accept   = (state == XFER) && sel_vld && sel_rdy;
    assign drained  = ~o_vld | i_ready;
    assign pkt_done = (state == FLUSH) && drained;

    always_comb begin
        o_port_rdy = '0;
        if (state == XFER) begin
            o_port_rdy[sel_q] = sel_rdy;
        end
    end

`ifdef CHAN_DATA_MUX_TIMEOUT_EN
    localparam int IDLEW = $clog2(TIMEOUT + 1);

    logic [IDLEW-1:0] idle_cnt;
    logic             abort_q;

    // Fires on the edge that would complete TIMEOUT consecutive XFER cycles without a beat.
    assign timeout_hit = (state == XFER) && !accept && (idle_cnt == IDLEW'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idle_cnt <= '0;
            abort_q  <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            if ((state == XFER) && !accept) begin
                idle_cnt <= idle_cnt + IDLEW'(1);
            end else begin
                idle_cnt <= '0;
            end
            if ((state == IDLE) && i_chan_en) begin
                abort_q <= 1'b0;
            end else if (timeout_hit) begin
                abort_q <= 1'b1;
            end
            if (pkt_done) begin
                o_err <= abort_q;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_err       = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_chan_en) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if ((accept && sel_eop) || timeout_hit) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (drained) begin
                    state_nxt = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (!i_chan_en) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A timeout either flags the beat still held for downstream as last, or emits a lone eop marker.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            sel_q     <= '0;
            beat_cnt  <= '0;
            o_data    <= '0;
            o_vld     <= 1'b0;
            o_eop     <= 1'b0;
            o_end     <= 1'b0;
            o_pkt_len <= '0;
        end else begin
            state <= state_nxt;
            o_end <= 1'b0;

            if ((state == IDLE) && i_chan_en) begin
                sel_q    <= i_chan_sel;
                beat_cnt <= '0;
            end

            if (accept) begin
                o_data <= sel_data;
                o_vld  <= 1'b1;
                o_eop  <= sel_eop;
                if (beat_cnt != '1) begin
                    beat_cnt <= beat_cnt + LENW'(1);
                end
            end else if (timeout_hit) begin
                o_vld <= o_vld & ~i_ready;
                o_eop <= 1'b1;
            end else if (i_ready || !o_vld) begin
                o_vld <= 1'b0;
                o_eop <= 1'b0;
            end

            if (pkt_done) begin
                o_end     <= 1'b1;
                o_pkt_len <= beat_cnt;
            end
        end
    end

endmodule
